i2c_sensor_target: RTL and testbench

Synthesizable I2C target (responder) for the greenhouse controller's two-wire bus: it answers the initiator in `main` on `scl`/`sda` as a sensor/register device. It holds a small 8-bit register bank that the initiator can read and write. A local host port lets on-chip logic load sensor values into that bank. It sits behind the open-drain pad pair: it consumes the pad's input data and produces a pull-low enable only, and never drives SDA high.

---
 rtl/i2c_sensor_target_if.sv | 25 ++
 rtl/i2c_sensor_target.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_sensor_target.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_sensor_target_if.sv
// Interface for i2c_sensor_target: open-drain pad pair, host load port and write-notify outputs.
interface i2c_sensor_target_if #(
    parameter int unsigned PW = 2
);
    logic          scl_in;
    logic          sda_in;
    logic          sda_oe;
    logic          load_en;
    logic [PW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          wr_strb;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    modport master (
        output scl_in, sda_in, load_en, load_addr, load_data,
        input  sda_oe, wr_strb, wr_addr, wr_data, busy
    );

    modport slave (
        input  scl_in, sda_in, load_en, load_addr, load_data,
        output sda_oe, wr_strb, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/i2c_sensor_target.sv
// I2C register-bank target with host load port; drives only an SDA pull-low enable.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_sensor_target #(
    parameter logic [6:0]  ADDR     = 7'h48,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic               clk,
    input  logic               rst,
    i2c_sensor_target_if.slave bus
);
    localparam int unsigned PW = $clog2(NUM_REGS);
    localparam int unsigned CW = 4;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK
    } state_t;

    logic [1:0]    r_scl_sync, r_sda_sync;
    logic          r_scl_d, r_sda_d;
    logic          w_scl, w_sda;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_tx, w_tx_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
    logic          r_ack, w_ack_nxt;
    logic          r_sda_oe, w_sda_oe_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_wr_strb, w_wr_strb_nxt;
    logic [PW-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]    r_wr_data, w_wr_data_nxt;
    logic          w_store;
    logic [7:0]    w_rd_cur, w_rd_next;
    logic [7:0]    r_regs [NUM_REGS];

    // Synchronizers reset high to match an idle bus, so release never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], bus.scl_in};
            r_sda_sync <= {r_sda_sync[0], bus.sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] r_scl_flt, r_sda_flt;
    logic       r_scl_m, r_sda_m;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_flt <= 2'b11;
            r_sda_flt <= 2'b11;
            r_scl_m   <= 1'b1;
            r_sda_m   <= 1'b1;
        end else begin
            r_scl_flt <= {r_scl_flt[0], r_scl_sync[1]};
            r_sda_flt <= {r_sda_flt[0], r_sda_sync[1]};
            r_scl_m   <= (r_scl_sync[1] & r_scl_flt[0]) | (r_scl_sync[1] & r_scl_flt[1]) |
                         (r_scl_flt[0] & r_scl_flt[1]);
            r_sda_m   <= (r_sda_sync[1] & r_sda_flt[0]) | (r_sda_sync[1] & r_sda_flt[1]) |
                         (r_sda_flt[0] & r_sda_flt[1]);
        end
    end

    assign w_scl = r_scl_m;
    assign w_sda = r_sda_m;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_ptr_inc  = r_ptr + PW'(1);
    assign w_rd_cur   = r_regs[r_ptr];
    assign w_rd_next  = r_regs[w_ptr_inc];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_ptr     <= '0;
            r_ack     <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_strb <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_ack     <= w_ack_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_strb <= w_wr_strb_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // Bus protocol: bits shift on SCL rise, every SDA drive change happens on SCL fall.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_ptr_nxt     = r_ptr;
        w_ack_nxt     = r_ack;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_wr_strb_nxt = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_store       = 1'b0;

        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end else if (w_scl_fall && r_cnt == CW'(8)) begin
                        w_sda_oe_nxt = 1'b1;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt  = S_IDLE;
                                w_sda_oe_nxt = 1'b0;
                            end
                        end else if (r_state == S_PTR) begin
                            w_state_nxt = S_PTR_ACK;
                            w_ptr_nxt   = r_shift[PW-1:0];
                        end else begin
                            w_state_nxt   = S_WACK;
                            w_store       = 1'b1;
                            w_wr_strb_nxt = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = r_shift;
                            w_ptr_nxt     = w_ptr_inc;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt = '0;
                        if (r_shift[0]) begin
                            w_state_nxt  = S_RDATA;
                            w_tx_nxt     = w_rd_cur;
                            w_sda_oe_nxt = ~w_rd_cur[7];
                        end else begin
                            w_state_nxt  = S_PTR;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_PTR_ACK, S_WACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt  = S_WDATA;
                        w_cnt_nxt    = '0;
                        w_sda_oe_nxt = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == CW'(7)) begin
                            w_state_nxt  = S_RACK;
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_tx_nxt     = {r_tx[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_tx[6];
                            w_cnt_nxt    = r_cnt + CW'(1);
                        end
                    end
                end
                S_RACK: begin
                    if (w_scl_rise) begin
                        w_ack_nxt = ~w_sda;
                    end else if (w_scl_fall) begin
                        if (r_ack) begin
                            w_state_nxt  = S_RDATA;
                            w_ptr_nxt    = w_ptr_inc;
                            w_tx_nxt     = w_rd_next;
                            w_sda_oe_nxt = ~w_rd_next[7];
                            w_cnt_nxt    = '0;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Host load is applied after the I2C store so it wins on a same-register collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_store)     r_regs[r_ptr]         <= r_shift;
            if (bus.load_en) r_regs[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.sda_oe  = r_sda_oe;
    assign bus.wr_strb = r_wr_strb;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bit-banged I2C initiator driving i2c_sensor_target, checked against a transaction-level register model.
module tb_i2c_sensor_target;
    localparam int unsigned NREG = 4;
    localparam int unsigned PW   = 2;
    localparam int unsigned Q    = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int unsigned LAT = 5;
`else
    localparam int unsigned LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic scl_drv, sda_drv;
    always #5 clk = ~clk;

    i2c_sensor_target_if #(.PW(PW)) bus ();
    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_sensor_target #(.ADDR(7'h48), .NUM_REGS(NREG)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]    m_regs [NREG];
    int            m_ptr;
    logic [PW+7:0] strb_q [$];
    logic [PW+7:0] exp_q  [$];

    always @(negedge clk) if (rst && bus.wr_strb) strb_q.push_back({bus.wr_addr, bus.wr_data});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_strobes();
        check("strb_count", 32'(strb_q.size()), 32'(exp_q.size()));
        while (strb_q.size() > 0 && exp_q.size() > 0)
            check("strb_payload", 32'(strb_q.pop_front()), 32'(exp_q.pop_front()));
        strb_q.delete();
        exp_q.delete();
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        sda_drv = 1'b0; wait_clks(Q);
        scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        sda_drv = 1'b1; wait_clks(Q);
    endtask

    // gbit >= 0 puts a one-clk SDA high pulse into that (zero) bit while SCL is high.
    task automatic write_byte(input logic [7:0] b, input bit collide, input logic [PW-1:0] caddr,
                              input logic [7:0] cdata, input int gbit, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; wait_clks(Q);
            scl_drv = 1'b1;
            if (i == gbit) begin
                wait_clks(Q); sda_drv = 1'b1; wait_clks(1); sda_drv = 1'b0; wait_clks(Q - 1);
            end else wait_clks(2 * Q);
            scl_drv = 1'b0;
        end
        sda_drv = 1'b1;
        if (collide) begin
            wait_clks(LAT - 1);
            bus.load_en = 1'b1; bus.load_addr = caddr; bus.load_data = cdata;
            wait_clks(1);
            bus.load_en = 1'b0;
            wait_clks(Q - LAT);
        end else wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        ack = ~bus.sda_in; wait_clks(Q);
        scl_drv = 1'b0;
    endtask

    task automatic wb(input logic [7:0] b, output bit ack);
        write_byte(b, 1'b0, '0, '0, -1, ack);
    endtask

    task automatic read_byte(input bit ack, output logic [7:0] d);
        sda_drv = 1'b1;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            wait_clks(Q); scl_drv = 1'b1;
            wait_clks(Q); d = {d[6:0], bus.sda_in};
            wait_clks(Q); scl_drv = 1'b0;
        end
        sda_drv = ack ? 1'b0 : 1'b1;
        wait_clks(Q); scl_drv = 1'b1;
        wait_clks(2 * Q); scl_drv = 1'b0;
    endtask

    task automatic host_load(input int a, input logic [7:0] d);
        bus.load_en = 1'b1; bus.load_addr = PW'(a); bus.load_data = d;
        wait_clks(1);
        bus.load_en = 1'b0;
        m_regs[PW'(a)] = d;
    endtask

    task automatic txn_write(input logic [7:0] pbyte, input int n, input logic [7:0] d [4]);
        bit ack;
        i2c_start();
        wb(8'h90, ack); check("w_addr_ack", 32'(ack), 32'd1);
        check("w_busy", 32'(bus.busy), 32'd1);
        wb(pbyte, ack); check("w_ptr_ack", 32'(ack), 32'd1);
        m_ptr = int'(pbyte) % NREG;
        for (int k = 0; k < n; k++) begin
            wb(d[k], ack); check($sformatf("w_data_ack%0d", k), 32'(ack), 32'd1);
            m_regs[PW'(m_ptr)] = d[k];
            exp_q.push_back({PW'(m_ptr), d[k]});
            m_ptr = (m_ptr + 1) % NREG;
        end
        i2c_stop();
        check_strobes();
    endtask

    task automatic txn_read(input int n, input bit setptr, input logic [7:0] pbyte);
        bit ack;
        logic [7:0] d;
        i2c_start();
        if (setptr) begin
            wb(8'h90, ack); check("r_waddr_ack", 32'(ack), 32'd1);
            wb(pbyte, ack); check("r_ptr_ack", 32'(ack), 32'd1);
            m_ptr = int'(pbyte) % NREG;
            i2c_start();
        end
        wb(8'h91, ack); check("r_addr_ack", 32'(ack), 32'd1);
        check("r_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, d);
            check($sformatf("r_data%0d_ptr%0d", k, m_ptr), 32'(d), 32'(m_regs[PW'(m_ptr)]));
            if (k < n - 1) m_ptr = (m_ptr + 1) % NREG;
        end
        wait_clks(LAT + 1);
        check("r_release_after_nack", 32'(bus.sda_oe), 32'd0);
        i2c_stop();
        check("r_busy_after_stop", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ack;
        logic [7:0] d4 [4];
        scl_drv = 1'b1; sda_drv = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset held while the bus toggles
        for (int i = 0; i < 12; i++) begin
            scl_drv = 1'($urandom); sda_drv = 1'($urandom);
            wait_clks(3);
            check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
        end
        check("rst_wr_strb", 32'(bus.wr_strb), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        scl_drv = 1'b1; sda_drv = 1'b1;
        wait_clks(4);
        rst = 1'b1;
        wait_clks(4);
        txn_read(1, 1'b1, 8'h00);

        // Directed write of two bytes from pointer 1, then read them back
        d4[0] = 8'hA5; d4[1] = 8'h3C; d4[2] = 8'h00; d4[3] = 8'h00;
        txn_write(8'h01, 2, d4);
        txn_read(2, 1'b1, 8'h01);

        // Read with wrap from reg 3 to reg 0
        host_load(3, 8'h77);
        host_load(0, 8'h11);
        txn_read(2, 1'b1, 8'h03);

        // Wrong address: no ACK, then the next byte is ignored
        i2c_start();
        wb(8'h92, ack); check("badaddr_ack", 32'(ack), 32'd0);
        check("badaddr_busy", 32'(bus.busy), 32'd0);
        wb(8'h90, ack); check("badaddr_ignored", 32'(ack), 32'd0);
        i2c_stop();

        // Host load collides with I2C store to reg 1
        i2c_start();
        wb(8'h90, ack); check("col_addr_ack", 32'(ack), 32'd1);
        wb(8'h01, ack); check("col_ptr_ack", 32'(ack), 32'd1);
        write_byte(8'hA5, 1'b1, PW'(1), 8'h5A, -1, ack);
        check("col_data_ack", 32'(ack), 32'd1);
        m_regs[1] = 8'h5A;
        exp_q.push_back({PW'(1), 8'hA5});
        m_ptr = 2;
        i2c_stop();
        check_strobes();
        txn_read(1, 1'b1, 8'h01);

        // STOP in the middle of a read byte (bit 3 of 0x08 releases SDA so STOP is possible)
        host_load(2, 8'h08);
        i2c_start();
        wb(8'h90, ack); wb(8'h02, ack);
        m_ptr = 2;
        i2c_start();
        wb(8'h91, ack); check("abort_addr_ack", 32'(ack), 32'd1);
        sda_drv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_clks(Q); scl_drv = 1'b1; wait_clks(2 * Q); scl_drv = 1'b0;
        end
        wait_clks(Q); sda_drv = 1'b0;
        wait_clks(Q); scl_drv = 1'b1;
        wait_clks(Q); sda_drv = 1'b1;
        wait_clks(LAT);
        check("abort_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wait_clks(Q); scl_drv = 1'b0;
            wait_clks(LAT + 1); check("abort_idle_oe", 32'(bus.sda_oe), 32'd0);
            wait_clks(Q); scl_drv = 1'b1;
        end
        wait_clks(Q);
        txn_read(1, 1'b0, 8'h00);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // One-clk SDA glitches while SCL is high must not act as START or STOP
        sda_drv = 1'b0; wait_clks(1); sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b0;
        wb(8'h90, ack); check("glitch_no_start", 32'(ack), 32'd0);
        i2c_stop();
        i2c_start();
        wb(8'h90, ack);
        write_byte(8'h00, 1'b0, '0, '0, 3, ack);
        check("glitch_no_stop", 32'(ack), 32'd1);
        m_ptr = 0;
        i2c_stop();
`endif

        // Randomized transactions against the register model
        for (int t = 0; t < 25; t++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                for (int k = 0; k < 4; k++) d4[k] = 8'($urandom);
                txn_write(8'($urandom), int'($urandom_range(1, 3)), d4);
            end else if (kind == 1) begin
                txn_read(int'($urandom_range(1, 3)), 1'b1, 8'($urandom));
            end else if (kind == 2) begin
                txn_read(int'($urandom_range(1, 3)), 1'b0, 8'h00);
            end else begin
                host_load(int'($urandom_range(0, NREG - 1)), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
